// File: rtl/reset_requester.sv
// Reset request initiator: turns single-cycle hard/soft/peripheral requests into timed, prioritised
// request pulses and confirms the generator honoured and released each one. Optional WAIT_REL timeout: RESET_REQ_TIMEOUT_EN.
module reset_requester #(
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CNT_W          = 21
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       req_hard,
    input  logic       req_soft,
    input  logic       req_peripheral,
    input  logic       mb_reset_in,
    input  logic       peripheral_reset_in,
    output logic       reset_hard,
    output logic       reset_soft,
    output logic       reset_peripheral,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [1:0] last_kind
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSERT   = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_PERIPH = 2'b01;
    localparam logic [1:0] KIND_SOFT   = 2'b10;
    localparam logic [1:0] KIND_HARD   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    // Pending/request vectors are ordered {hard, soft, peripheral}.
    function automatic logic [1:0] pick_kind(input logic [2:0] cand);
        logic [1:0] k;
        if (cand[2]) begin
            k = KIND_HARD;
        end else if (cand[1]) begin
            k = KIND_SOFT;
        end else if (cand[0]) begin
            k = KIND_PERIPH;
        end else begin
            k = KIND_NONE;
        end
        return k;
    endfunction

    function automatic logic [2:0] kind_mask(input logic [1:0] k);
        logic [2:0] m;
        case (k)
            KIND_HARD:   m = 3'b100;
            KIND_SOFT:   m = 3'b010;
            KIND_PERIPH: m = 3'b001;
            default:     m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic ack_of(input logic [1:0] k, input logic mb, input logic pr);
        logic a;
        case (k)
            KIND_HARD:   a = mb & pr;
            KIND_SOFT:   a = mb;
            KIND_PERIPH: a = pr;
            default:     a = 1'b0;
        endcase
        return a;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic [2:0]       out_q, out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [1:0]       last_q, last_d;
    logic             timeout_d;

    logic [2:0]       req_v_s;
    logic [2:0]       cand_s;
    logic             ack_sig_s;

    assign req_v_s   = {req_hard, req_soft, req_peripheral};
    assign cand_s    = pend_q | req_v_s;
    assign ack_sig_s = ack_of(kind_q, mb_reset_in, peripheral_reset_in);

    // Next-state logic for the request FSM, pending set and acknowledge tracking
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_s != 3'b000) begin
                    kind_d  = pick_kind(cand_s);
                    pend_d  = cand_s & ~kind_mask(pick_kind(cand_s));
                    cnt_d   = PULSE_LOAD;
                    ack_d   = 1'b0;
                    state_d = ST_ASSERT;
                end else begin
                    pend_d  = pend_q;
                end
            end
            ST_ASSERT: begin
                // A repeat of the kind being served is absorbed into the current pulse.
                pend_d = pend_q | (req_v_s & ~kind_mask(kind_q));
                ack_d  = ack_q | ack_sig_s;
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = ST_WAIT_REL;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT_REL: begin
                pend_d = pend_q | req_v_s;
                if (ack_q && !ack_sig_s) begin
                    done_d  = 1'b1;
                    last_d  = kind_q;
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ack_d = ack_q | ack_sig_s;
`ifdef RESET_REQ_TIMEOUT_EN
                    if (cnt_q == CNT_ZERO) begin
                        timeout_d = 1'b1;
                        last_d    = kind_q;
                        ack_d     = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q - CNT_ONE;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase
        out_d  = (state_d == ST_ASSERT) ? kind_mask(kind_d) : 3'b000;
        busy_d = (state_d != ST_IDLE);
    end

    // State, pending set and registered outputs
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 3'b000;
            kind_q  <= KIND_NONE;
            cnt_q   <= CNT_ZERO;
            ack_q   <= 1'b0;
            out_q   <= 3'b000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= KIND_NONE;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

`ifdef RESET_REQ_TIMEOUT_EN
    logic timeout_q;

    // Registered abandon pulse
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = timeout_d;
    assign timeout          = 1'b0;
`endif

    assign reset_hard       = out_q[2];
    assign reset_soft       = out_q[1];
    assign reset_peripheral = out_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign last_kind        = last_q;

endmodule

// File: tb/tb_reset_requester.sv
// Self-checking bench for reset_requester: directed scenarios plus a randomized run against a
// transaction-level reference model. Build with RESET_REQ_TIMEOUT_EN to exercise the timeout path.
module tb_reset_requester;

    localparam int P = 16;
    localparam int T = 64;
`ifdef RESET_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       req_hard = 1'b0, req_soft = 1'b0, req_peripheral = 1'b0;
    logic       mb_reset_in = 1'b0, peripheral_reset_in = 1'b0;
    logic       reset_hard, reset_soft, reset_peripheral, busy, done, timeout;
    logic [1:0] last_kind;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: kinds 1=peripheral 2=soft 3=hard
    bit         m_pend[4];
    int         m_phase;      // 0 idle, 1 pulsing, 2 waiting for release
    int         m_kind, m_left, m_wait;
    bit         m_acked, m_done, m_to;
    logic [1:0] m_last;

    // generator model and event log
    bit gen_auto = 1'b0, man_hard = 1'b0;
    int gen_d = 3, gen_l = 40, gen_start = 0, gen_end = 0, gen_kind = 0, prev_kind = 0;
    int rise_k[$], rise_t[$], done_k[$], done_t[$], to_t[$], inj_soft[$];
    int hi_cnt[4];
    int n_multi;

    reset_requester #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .CNT_W(21)) dut (
        .clk(clk), .i_reset(i_reset),
        .req_hard(req_hard), .req_soft(req_soft), .req_peripheral(req_peripheral),
        .mb_reset_in(mb_reset_in), .peripheral_reset_in(peripheral_reset_in),
        .reset_hard(reset_hard), .reset_soft(reset_soft), .reset_peripheral(reset_peripheral),
        .busy(busy), .done(done), .timeout(timeout), .last_kind(last_kind)
    );

    always #5 clk = ~clk;

    function automatic int dut_kind();
        if (reset_hard) return 3;
        if (reset_soft) return 2;
        if (reset_peripheral) return 1;
        return 0;
    endfunction

    function automatic bit onehot();
        return (int'(reset_hard) + int'(reset_soft) + int'(reset_peripheral)) <= 1;
    endfunction

    function automatic bit ack_of(int k, logic mb, logic pr);
        if (k == 3) return mb && pr;
        if (k == 2) return mb;
        return pr;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_pend[k] = 1'b0;
        m_phase = 0; m_kind = 0; m_left = 0; m_wait = 0;
        m_acked = 1'b0; m_done = 1'b0; m_to = 1'b0; m_last = 2'b00;
    endtask

    task automatic model_step(input logic h, input logic s, input logic p, input logic mb, input logic pr);
        bit rq[4];
        int best;
        bit a;
        rq[0] = 1'b0; rq[1] = p; rq[2] = s; rq[3] = h;
        m_done = 1'b0; m_to = 1'b0;
        a = ack_of(m_kind, mb, pr);
        if (m_phase == 0) begin
            best = 0;
            for (int k = 1; k < 4; k++) if (m_pend[k] || rq[k]) best = k;
            for (int k = 1; k < 4; k++) m_pend[k] = (m_pend[k] || rq[k]) && (k != best);
            if (best != 0) begin
                m_phase = 1; m_kind = best; m_left = P; m_acked = 1'b0;
            end
        end else if (m_phase == 1) begin
            for (int k = 1; k < 4; k++) if (rq[k] && k != m_kind) m_pend[k] = 1'b1;
            if (a) m_acked = 1'b1;
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_wait = 0; end
        end else begin
            for (int k = 1; k < 4; k++) if (rq[k]) m_pend[k] = 1'b1;
            if (m_acked && !a) begin
                m_done = 1'b1; m_last = 2'(m_kind); m_acked = 1'b0; m_phase = 0;
            end else begin
                if (a) m_acked = 1'b1;
                m_wait++;
                if (TO_EN && m_wait == T) begin
                    m_to = 1'b1; m_last = 2'(m_kind); m_acked = 1'b0; m_phase = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic h, s, p, m, r, rs;
        int k;
        h = req_hard; s = req_soft; p = req_peripheral;
        m = mb_reset_in; r = peripheral_reset_in; rs = i_reset;
        @(posedge clk);
        #1;
        if (rs || i_reset) model_reset();
        else model_step(h, s, p, m, r);
        cyc++;
        req_hard = 1'b0; req_soft = 1'b0; req_peripheral = 1'b0;
        if (gen_auto) begin
            k = dut_kind();
            if (k != 0 && prev_kind == 0) begin
                gen_kind = k; gen_start = cyc - 1 + gen_d; gen_end = gen_start + gen_l;
            end
            prev_kind = k;
            mb_reset_in         = (gen_kind >= 2) && cyc >= gen_start && cyc < gen_end;
            peripheral_reset_in = (gen_kind == 3 || gen_kind == 1) && cyc >= gen_start && cyc < gen_end;
        end
    endtask

    task automatic gen_on(input int d, input int l);
        gen_d = d; gen_l = l; gen_kind = 0; prev_kind = dut_kind(); gen_auto = 1'b1;
    endtask

    task automatic gen_off();
        gen_auto = 1'b0; man_hard = 1'b0; mb_reset_in = 1'b0; peripheral_reset_in = 1'b0;
    endtask

    task automatic clear_log();
        rise_k.delete(); rise_t.delete(); done_k.delete(); done_t.delete(); to_t.delete(); inj_soft.delete();
        for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
        n_multi = 0;
    endtask

    // Runs n cycles from reference edge t0 and logs pulse starts, completions and abandons.
    task automatic collect(input int n, input int t0);
        int k, prev, e, rel;
        prev = dut_kind();
        for (int i = 0; i < n; i++) begin
            rel = cyc - t0;
            foreach (inj_soft[j]) if (inj_soft[j] == rel) req_soft = 1'b1;
            if (man_hard) begin
                // mb alone for a while, a gap, then both together
                mb_reset_in         = (rel >= 2 && rel < 25) || (rel >= 30 && rel < 35);
                peripheral_reset_in = (rel >= 30 && rel < 35);
            end
            tick();
            e = cyc - 1 - t0;
            k = dut_kind();
            if (k != 0) hi_cnt[k]++;
            if (k != 0 && prev == 0) begin rise_k.push_back(k); rise_t.push_back(e); end
            if (!onehot()) n_multi++;
            if (done) begin done_k.push_back(int'(last_kind)); done_t.push_back(e); end
            if (timeout) to_t.push_back(e);
            prev = k;
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic test_reset();
        i_reset = 1'b1;
        req_hard = 1'b1;
        tick(); tick();
        n_checks++; if ({reset_hard, reset_soft, reset_peripheral} !== 3'b000) $display("FAIL rst_outputs: got %b expected 000", {reset_hard, reset_soft, reset_peripheral}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0 || timeout !== 1'b0) $display("FAIL rst_done_timeout: got %b%b expected 00", done, timeout); else n_pass++;
        n_checks++; if (last_kind !== 2'b00) $display("FAIL rst_last_kind: got %b expected 00", last_kind); else n_pass++;
        i_reset = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle_after_release: busy got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single_soft();
        int t0;
        clear_log();
        gen_on(3, 40);
        req_soft = 1'b1; t0 = cyc;
        collect(100, t0);
        gen_off();
        n_checks++; if (hi_cnt[2] !== P) $display("FAIL soft_width: got %0d expected %0d", hi_cnt[2], P); else n_pass++;
        n_checks++; if (qget(rise_t, 0) !== 0) $display("FAIL soft_latency: got %0d expected 0", qget(rise_t, 0)); else n_pass++;
        n_checks++; if (done_t.size() !== 1) $display("FAIL soft_done_count: got %0d expected 1", done_t.size()); else n_pass++;
        n_checks++; if (qget(done_t, 0) !== 43) $display("FAIL soft_done_time: got %0d expected 43", qget(done_t, 0)); else n_pass++;
        n_checks++; if (qget(done_k, 0) !== 2) $display("FAIL soft_last_kind: got %0d expected 2", qget(done_k, 0)); else n_pass++;
        n_checks++; if (hi_cnt[1] + hi_cnt[3] !== 0) $display("FAIL soft_other_outputs: got %0d expected 0", hi_cnt[1] + hi_cnt[3]); else n_pass++;
    endtask

    task automatic test_priority();
        int t0;
        clear_log();
        gen_on(2, 5);
        req_hard = 1'b1; req_peripheral = 1'b1; t0 = cyc;
        collect(120, t0);
        gen_off();
        n_checks++; if (rise_k.size() !== 2) $display("FAIL prio_pulse_count: got %0d expected 2", rise_k.size()); else n_pass++;
        n_checks++; if (qget(rise_k, 0) !== 3 || qget(rise_k, 1) !== 1) $display("FAIL prio_order: got %0d,%0d expected 3,1", qget(rise_k, 0), qget(rise_k, 1)); else n_pass++;
        n_checks++; if (qget(done_k, 0) !== 3 || qget(done_k, 1) !== 1) $display("FAIL prio_last_kind: got %0d,%0d expected 3,1", qget(done_k, 0), qget(done_k, 1)); else n_pass++;
        n_checks++; if (qget(done_t, 0) !== 17) $display("FAIL prio_first_done: got %0d expected 17", qget(done_t, 0)); else n_pass++;
        n_checks++; if (qget(rise_t, 1) !== 18) $display("FAIL prio_gap: got %0d expected 18", qget(rise_t, 1)); else n_pass++;
        n_checks++; if (n_multi !== 0) $display("FAIL prio_onehot: got %0d cycles expected 0", n_multi); else n_pass++;
    endtask

    task automatic test_absorb();
        int t0;
        clear_log();
        gen_on(3, 40);
        inj_soft.push_back(5);
        inj_soft.push_back(20);
        req_soft = 1'b1; t0 = cyc;
        collect(160, t0);
        gen_off();
        n_checks++; if (rise_k.size() !== 2) $display("FAIL absorb_pulse_count: got %0d expected 2", rise_k.size()); else n_pass++;
        n_checks++; if (done_t.size() !== 2) $display("FAIL absorb_done_count: got %0d expected 2", done_t.size()); else n_pass++;
        n_checks++; if (qget(rise_t, 1) !== 44) $display("FAIL absorb_second_start: got %0d expected 44", qget(rise_t, 1)); else n_pass++;
        n_checks++; if (qget(done_t, 1) !== 87) $display("FAIL absorb_second_done: got %0d expected 87", qget(done_t, 1)); else n_pass++;
    endtask

    task automatic test_hard_ack();
        int t0;
        clear_log();
        man_hard = 1'b1;
        req_hard = 1'b1; t0 = cyc;
        collect(60, t0);
        gen_off();
        n_checks++; if (done_t.size() !== 1) $display("FAIL hard_done_count: got %0d expected 1", done_t.size()); else n_pass++;
        n_checks++; if (qget(done_t, 0) !== 35) $display("FAIL hard_done_time: got %0d expected 35", qget(done_t, 0)); else n_pass++;
        n_checks++; if (qget(done_k, 0) !== 3) $display("FAIL hard_last_kind: got %0d expected 3", qget(done_k, 0)); else n_pass++;
        n_checks++; if (to_t.size() !== 0) $display("FAIL hard_no_timeout: got %0d expected 0", to_t.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        int t0;
        clear_log();
        req_hard = 1'b1; t0 = cyc;
        collect(120, t0);
        n_checks++; if (done_t.size() !== 0) $display("FAIL to_no_done: got %0d expected 0", done_t.size()); else n_pass++;
        n_checks++; if (hi_cnt[3] !== P) $display("FAIL to_width: got %0d expected %0d", hi_cnt[3], P); else n_pass++;
`ifdef RESET_REQ_TIMEOUT_EN
        n_checks++; if (to_t.size() !== 1) $display("FAIL to_count: got %0d expected 1", to_t.size()); else n_pass++;
        n_checks++; if (qget(to_t, 0) !== P + T) $display("FAIL to_time: got %0d expected %0d", qget(to_t, 0), P + T); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (last_kind !== 2'b11) $display("FAIL to_last_kind: got %b expected 11", last_kind); else n_pass++;
`else
        n_checks++; if (to_t.size() !== 0) $display("FAIL to_never: got %0d expected 0", to_t.size()); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL to_still_waiting: got %b expected 1", busy); else n_pass++;
        mb_reset_in = 1'b1; peripheral_reset_in = 1'b1;
        tick(); tick();
        mb_reset_in = 1'b0; peripheral_reset_in = 1'b0;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL to_late_done: got %b expected 1", done); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL to_late_idle: got %b expected 0", busy); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        clear_log();
        req_hard = 1'b1; req_soft = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (reset_hard !== 1'b1) $display("FAIL mid_pre_hard: got %b expected 1", reset_hard); else n_pass++;
        #2;
        i_reset = 1'b1;
        #1;
        n_checks++; if (reset_hard !== 1'b0) $display("FAIL mid_async_drop: got %b expected 0", reset_hard); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_async_busy: got %b expected 0", busy); else n_pass++;
        tick(); tick();
        i_reset = 1'b0;
        collect(60, cyc);
        n_checks++; if (rise_k.size() !== 0) $display("FAIL mid_no_pulses: got %0d expected 0", rise_k.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0 || last_kind !== 2'b00) $display("FAIL mid_idle_state: got busy %b kind %b expected 0 00", busy, last_kind); else n_pass++;
    endtask

    task automatic test_random();
        int bad_out, bad_busy, bad_done, bad_to, bad_last, bad_hot, budget;
        bad_out = 0; bad_busy = 0; bad_done = 0; bad_to = 0; bad_last = 0; bad_hot = 0;
        gen_on(1, 1);
        for (int i = 0; i < 1500; i++) begin
            req_hard       = ($urandom_range(23, 0) == 0);
            req_soft       = ($urandom_range(11, 0) == 0);
            req_peripheral = ($urandom_range(11, 0) == 0);
            gen_d = int'($urandom_range(20, 1));
            gen_l = int'($urandom_range(30, 1));
            tick();
            if (dut_kind() !== (m_phase == 1 ? m_kind : 0)) bad_out++;
            if (busy !== (m_phase != 0)) bad_busy++;
            if (done !== m_done) bad_done++;
            if (timeout !== m_to) bad_to++;
            if (last_kind !== m_last) bad_last++;
            if (!onehot()) bad_hot++;
        end
        budget = 0;
        while ((busy || m_phase != 0 || m_pend[1] || m_pend[2] || m_pend[3]) && budget < 1000) begin
            tick();
            if (dut_kind() !== (m_phase == 1 ? m_kind : 0)) bad_out++;
            if (done !== m_done) bad_done++;
            budget++;
        end
        gen_off();
        n_checks++; if (bad_out !== 0) $display("FAIL rand_outputs: got %0d bad cycles expected 0", bad_out); else n_pass++;
        n_checks++; if (bad_busy !== 0) $display("FAIL rand_busy: got %0d bad cycles expected 0", bad_busy); else n_pass++;
        n_checks++; if (bad_done !== 0) $display("FAIL rand_done: got %0d bad cycles expected 0", bad_done); else n_pass++;
        n_checks++; if (bad_to !== 0) $display("FAIL rand_timeout: got %0d bad cycles expected 0", bad_to); else n_pass++;
        n_checks++; if (bad_last !== 0) $display("FAIL rand_last_kind: got %0d bad cycles expected 0", bad_last); else n_pass++;
        n_checks++; if (bad_hot !== 0) $display("FAIL rand_onehot: got %0d bad cycles expected 0", bad_hot); else n_pass++;
        n_checks++; if (budget >= 1000) $display("FAIL rand_drain: got %0d cycles expected under 1000", budget); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_soft();
        test_priority();
        test_absorb();
        test_hard_ack();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
